// File: rtl/pnr_pkg.sv
// Shared definitions for the PNR ADC FIFO reader: register offsets, CTRL bits,
// FSM state encoding and the DATA valid-bit position.
package pnr_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_POPCNT = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;

  localparam int VALID_BIT = 31;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT,
    ACK,
    FLUSH
  } state_t;

endpackage

// File: rtl/pnr_adc_fifo_reader_if.sv
// FIFO read port and system register bus of the PNR ADC FIFO reader.
// slave = the reader block, master = the bus/FIFO side driving it.
interface pnr_adc_fifo_reader_if #(
  parameter int ADDR_W   = 20,
  parameter int SAMPLE_W = 14
);

  logic [SAMPLE_W-1:0] fifo_dout;
  logic                fifo_empty;
  logic                fifo_rd_en;
  logic [ADDR_W-1:0]   sys_addr;
  logic [31:0]         sys_wdata;
  logic                sys_wen;
  logic                sys_ren;
  logic [31:0]         sys_rdata;
  logic                sys_ack;
  logic                flushing;

  modport slave (
    input  fifo_dout, fifo_empty, sys_addr, sys_wdata, sys_wen, sys_ren,
    output fifo_rd_en, sys_rdata, sys_ack, flushing
  );

  modport master (
    output fifo_dout, fifo_empty, sys_addr, sys_wdata, sys_wen, sys_ren,
    input  fifo_rd_en, sys_rdata, sys_ack, flushing
  );

endinterface

// File: rtl/pnr_reader_regdec.sv
// Address decode and read-data formatting for the PNR ADC FIFO reader.
// Macro PNR_READER_SIGNEXT_EN: DATA sign-extends the sample up to bit 30.
module pnr_reader_regdec
  import pnr_pkg::*;
#(
  parameter int SAMPLE_W = 14,
  parameter int CNT_W    = 32
) (
  input  logic [1:0]          reg_sel,
  input  logic                flushing,
  input  logic                fifo_empty,
  input  logic [CNT_W-1:0]    pop_cnt,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                is_data,
  output logic                is_ctrl,
  output logic [31:0]         reg_word,
  output logic [31:0]         data_word
);

  assign is_data = (reg_sel == ADDR_DATA);
  assign is_ctrl = (reg_sel == ADDR_CTRL);

  // DATA here is the empty-FIFO answer; popped samples use data_word instead.
  always_comb begin
    reg_word = '0;
    case (reg_sel)
      ADDR_STATUS: reg_word = {30'b0, flushing, fifo_empty};
      ADDR_POPCNT: reg_word = 32'(pop_cnt);
      default:     reg_word = '0;
    endcase
  end

`ifdef PNR_READER_SIGNEXT_EN
  assign data_word = {1'b1, {(VALID_BIT - SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
`else
  assign data_word = {1'b1, {(VALID_BIT - SAMPLE_W){1'b0}}, sample};
`endif

endmodule

// File: rtl/pnr_adc_fifo_reader.sv
// Read side of the PNR ADC sample FIFO: drains samples to the CPU over the
// register bus, reports status and a pop count, and runs hardware flushes.
//
// state | meaning
// IDLE  | waiting for a bus access
// POP   | fifo_rd_en pulsed, FIFO output settling
// WAIT  | capture fifo_dout into read data, bump pop count
// ACK   | sys_ack high for one cycle
// FLUSH | popping every other cycle until the FIFO reports empty
module pnr_adc_fifo_reader
  import pnr_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int SAMPLE_W = 14,
  parameter int CNT_W    = 32
) (
  input  logic ADC_CLK,
  input  logic rstn_i,
  pnr_adc_fifo_reader_if.slave bus
);

  state_t           state_q, state_d;
  logic             gap_q, gap_d;
  logic             ack_q, ack_d;
  logic             rd_en_q, rd_en_d;
  logic             flush_q, flush_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;

  logic             is_data, is_ctrl;
  logic [31:0]      reg_word, data_word;
  logic             unused_bits;

  assign unused_bits = ^{bus.sys_addr[ADDR_W-1:4], bus.sys_addr[1:0], bus.sys_wdata[31:2]};

  pnr_reader_regdec #(
    .SAMPLE_W (SAMPLE_W),
    .CNT_W    (CNT_W)
  ) u_regdec (
    .reg_sel    (bus.sys_addr[3:2]),
    .flushing   (flush_q),
    .fifo_empty (bus.fifo_empty),
    .pop_cnt    (pop_cnt_q),
    .sample     (bus.fifo_dout),
    .is_data    (is_data),
    .is_ctrl    (is_ctrl),
    .reg_word   (reg_word),
    .data_word  (data_word)
  );

  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      gap_q     <= 1'b0;
      ack_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      flush_q   <= 1'b0;
      rdata_q   <= '0;
      pop_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      ack_q     <= ack_d;
      rd_en_q   <= rd_en_d;
      flush_q   <= flush_d;
      rdata_q   <= rdata_d;
      pop_cnt_q <= pop_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    ack_d     = 1'b0;
    rd_en_d   = 1'b0;
    flush_d   = flush_q;
    rdata_d   = rdata_q;
    pop_cnt_d = pop_cnt_q;

    case (state_q)
      IDLE: begin
        gap_d = 1'b0;
        if (bus.sys_wen) begin
          rdata_d = '0;
          if (is_ctrl && bus.sys_wdata[CTRL_CLR])
            pop_cnt_d = '0;
          // A flush write is acknowledged on entry, not when the flush ends.
          if (is_ctrl && bus.sys_wdata[CTRL_FLUSH]) begin
            state_d = FLUSH;
            flush_d = 1'b1;
            ack_d   = 1'b1;
          end else begin
            state_d = ACK;
            ack_d   = 1'b1;
          end
        end else if (bus.sys_ren) begin
          if (is_data && !bus.fifo_empty) begin
            state_d = POP;
            rd_en_d = 1'b1;
          end else begin
            rdata_d = reg_word;
            state_d = ACK;
            ack_d   = 1'b1;
          end
        end
      end

      POP: state_d = WAIT;

      WAIT: begin
        rdata_d   = data_word;
        pop_cnt_d = pop_cnt_q + CNT_W'(1);
        state_d   = ACK;
        ack_d     = 1'b1;
      end

      ACK: state_d = IDLE;

      FLUSH: begin
        if (bus.sys_ren && !bus.sys_wen) begin
          rdata_d = '0;
          ack_d   = 1'b1;
        end
        // Gap cycle after each pop lets fifo_empty catch up before deciding again.
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (!bus.fifo_empty) begin
          rd_en_d = 1'b1;
          gap_d   = 1'b1;
        end else begin
          state_d = IDLE;
          flush_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.sys_ack    = ack_q;
  assign bus.sys_rdata  = rdata_q;
  assign bus.flushing   = flush_q;

endmodule
